// File: rtl/mux_n1_scan.sv
// N:1 registered multiplexer with a manual select and a round-robin channel
// sequencer that dwells a fixed number of cycles on each channel.
module mux_n1_scan #(
  parameter int WIDTH = 4,
  parameter int CH    = 4,
  parameter int DWELL = 4,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH*WIDTH-1:0]   din,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mode,
  input  logic                  hold,
  output logic [WIDTH-1:0]      y,
  output logic [SEL_W-1:0]      ch,
  output logic                  sw
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CH - 1);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    SCAN   = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   cnt_next;
  logic [SEL_W-1:0]   ch_next;
  logic [WIDTH-1:0]   y_next;
  logic [WIDTH-1:0]   chan [CH];

  // Split the packed input bus into one word per channel.
  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
      assign chan[gi] = din[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Operating state follows the mode/hold inputs sampled at this edge.
  always_comb begin
    if (!mode) begin
      state_next = MANUAL;
    end else if (hold) begin
      state_next = HOLD;
    end else begin
      state_next = SCAN;
    end
  end

  // Next channel and dwell count. The edge that first enters SCAN from
  // MANUAL keeps the channel and starts the dwell count from zero, so the
  // first step lands DWELL edges later. Leaving to MANUAL acts immediately.
  always_comb begin
    ch_next  = ch;
    cnt_next = cnt_reg;
    case (state_next)
      MANUAL: begin
        cnt_next = '0;
        if (int'(sel) < CH) begin
          ch_next = sel;
        end
      end
      HOLD: begin
        // Channel and count frozen; scanning resumes where it left off.
        ch_next  = ch;
        cnt_next = cnt_reg;
      end
      default: begin
        if (state_reg == MANUAL) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          // Explicit wrap so non-power-of-two channel counts work.
          ch_next  = (ch == CH_LAST) ? '0 : ch + 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
    endcase
  end

  // Data mux driven by the channel that will be latched this edge.
  always_comb begin
    y_next = '0;
    for (int k = 0; k < CH; k++) begin
      if (ch_next == SEL_W'(k)) begin
        y_next = chan[k];
      end
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= MANUAL;
      cnt_reg   <= '0;
      ch        <= '0;
      y         <= '0;
      sw        <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ch        <= ch_next;
      y         <= y_next;
      sw        <= (ch_next != ch);
    end
  end

endmodule

// File: tb/tb_mux_n1_scan.sv
// Directed bench for mux_n1_scan: a DWELL=2 instance for reset, manual,
// scan, hold and mid-scan reset behaviour, and a DWELL=1 instance for
// continuous stepping.
module tb_mux_n1_scan;

  localparam int WIDTH = 4;
  localparam int CH    = 3;
  localparam int SEL_W = 2;

  logic                clk;
  logic                rst;
  logic                rst1;
  logic [CH*WIDTH-1:0] din;
  logic [SEL_W-1:0]    sel;
  logic                mode;
  logic                mode1;
  logic                hold;
  logic                hold1;
  logic [WIDTH-1:0]    y;
  logic [SEL_W-1:0]    ch;
  logic                sw;
  logic [WIDTH-1:0]    y1;
  logic [SEL_W-1:0]    ch1;
  logic                sw1;

  int tests;
  int fails;

  mux_n1_scan #(.WIDTH(WIDTH), .CH(CH), .DWELL(2), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .hold(hold),
    .y(y), .ch(ch), .sw(sw)
  );

  mux_n1_scan #(.WIDTH(WIDTH), .CH(CH), .DWELL(1), .SEL_W(SEL_W)) dut1 (
    .clk(clk), .rst(rst1), .din(din), .sel(sel), .mode(mode1), .hold(hold1),
    .y(y1), .ch(ch1), .sw(sw1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic             mode;
    logic             hold;
    logic [WIDTH-1:0] y;
    logic [SEL_W-1:0] ch;
    logic             sw;
  } vec_t;

  vec_t vt [15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic expect_main(input string tag, input logic [WIDTH-1:0] ey,
                             input logic [SEL_W-1:0] ech, input logic esw);
    $display("[TB] %s: y=%h ch=%0d sw=%0d", tag, y, ch, sw);
    check({tag, ".y"},  32'(y),  32'(ey));
    check({tag, ".ch"}, 32'(ch), 32'(ech));
    check({tag, ".sw"}, 32'(sw), 32'(esw));
  endtask

  task automatic expect_d1(input string tag, input logic [WIDTH-1:0] ey,
                           input logic [SEL_W-1:0] ech, input logic esw);
    $display("[TB] %s: y=%h ch=%0d sw=%0d", tag, y1, ch1, sw1);
    check({tag, ".y"},  32'(y1),  32'(ey));
    check({tag, ".ch"}, 32'(ch1), 32'(ech));
    check({tag, ".sw"}, 32'(sw1), 32'(esw));
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // Manual select, then entry into SCAN from ch=2 with DWELL=2.
    vt[0]  = '{2'd2, 1'b0, 1'b0, 4'hC, 2'd2, 1'b1};
    vt[1]  = '{2'd2, 1'b0, 1'b0, 4'hC, 2'd2, 1'b0};
    vt[2]  = '{2'd3, 1'b0, 1'b0, 4'hC, 2'd2, 1'b0};
    vt[3]  = '{2'd3, 1'b1, 1'b0, 4'hC, 2'd2, 1'b0};
    vt[4]  = '{2'd3, 1'b1, 1'b0, 4'hC, 2'd2, 1'b0};
    vt[5]  = '{2'd3, 1'b1, 1'b0, 4'hA, 2'd0, 1'b1};
    vt[6]  = '{2'd3, 1'b1, 1'b0, 4'hA, 2'd0, 1'b0};
    vt[7]  = '{2'd3, 1'b1, 1'b0, 4'hB, 2'd1, 1'b1};
    vt[8]  = '{2'd3, 1'b1, 1'b0, 4'hB, 2'd1, 1'b0};
    vt[9]  = '{2'd3, 1'b1, 1'b0, 4'hC, 2'd2, 1'b1};
    vt[10] = '{2'd3, 1'b1, 1'b0, 4'hC, 2'd2, 1'b0};
    vt[11] = '{2'd3, 1'b1, 1'b0, 4'hA, 2'd0, 1'b1};
    vt[12] = '{2'd3, 1'b1, 1'b0, 4'hA, 2'd0, 1'b0};
    vt[13] = '{2'd3, 1'b1, 1'b0, 4'hB, 2'd1, 1'b1};
    vt[14] = '{2'd3, 1'b1, 1'b0, 4'hB, 2'd1, 1'b0};

    rst   = 1'b1;
    rst1  = 1'b1;
    mode  = 1'b0;
    mode1 = 1'b0;
    hold  = 1'b0;
    hold1 = 1'b0;
    sel   = '0;
    din   = '0;

    // Reset held: outputs stay at zero whatever the inputs do.
    for (int i = 0; i < 4; i++) begin
      din  = 12'($urandom);
      sel  = 2'($urandom);
      mode = 1'($urandom);
      step();
      expect_main($sformatf("rst%0d", i), 4'h0, 2'd0, 1'b0);
    end

    din  = {4'hC, 4'hB, 4'hA};
    sel  = 2'd0;
    mode = 1'b0;
    rst  = 1'b0;
    step();
    expect_main("release", 4'hA, 2'd0, 1'b0);

    for (int i = 0; i < 15; i++) begin
      sel  = vt[i].sel;
      mode = vt[i].mode;
      hold = vt[i].hold;
      step();
      expect_main($sformatf("vec%0d", i), vt[i].y, vt[i].ch, vt[i].sw);
    end

    // HOLD with one dwell cycle already spent on ch=1.
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) din[7:4] = 4'h5;
      step();
      expect_main($sformatf("hold%0d", i), (i >= 2) ? 4'h5 : 4'hB, 2'd1, 1'b0);
    end
    din[7:4] = 4'hB;
    hold = 1'b0;
    step();
    expect_main("resume", 4'hC, 2'd2, 1'b1);
    step();
    expect_main("scan_a", 4'hC, 2'd2, 1'b0);
    step();
    expect_main("scan_b", 4'hA, 2'd0, 1'b1);
    step();
    expect_main("scan_c", 4'hA, 2'd0, 1'b0);
    step();
    expect_main("scan_d", 4'hB, 2'd1, 1'b1);

    // SCAN -> MANUAL acts on the next edge; re-entering SCAN restarts the count.
    mode = 1'b0;
    sel  = 2'd0;
    step();
    expect_main("to_manual", 4'hA, 2'd0, 1'b1);
    mode = 1'b1;
    step();
    expect_main("rescan0", 4'hA, 2'd0, 1'b0);
    step();
    expect_main("rescan1", 4'hA, 2'd0, 1'b0);
    step();
    expect_main("rescan2", 4'hB, 2'd1, 1'b1);
    step();
    expect_main("rescan3", 4'hB, 2'd1, 1'b0);
    step();
    expect_main("rescan4", 4'hC, 2'd2, 1'b1);

    // Asynchronous reset pulse between edges while scanning at ch=2.
    #2;
    rst = 1'b1;
    #1;
    expect_main("async_rst", 4'h0, 2'd0, 1'b0);
    #1;
    rst = 1'b0;
    step();
    expect_main("post_rst0", 4'hA, 2'd0, 1'b0);
    step();
    expect_main("post_rst1", 4'hA, 2'd0, 1'b0);
    step();
    expect_main("post_rst2", 4'hB, 2'd1, 1'b1);

    // DWELL=1: after the entry edge the channel steps on every edge.
    mode1 = 1'b1;
    rst1  = 1'b0;
    step();
    expect_d1("d1_0", 4'hA, 2'd0, 1'b0);
    step();
    expect_d1("d1_1", 4'hB, 2'd1, 1'b1);
    step();
    expect_d1("d1_2", 4'hC, 2'd2, 1'b1);
    step();
    expect_d1("d1_3", 4'hA, 2'd0, 1'b1);
    step();
    expect_d1("d1_4", 4'hB, 2'd1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
